// File: rtl/ddfs_pkg.sv
// Shared types, default widths and helpers for the DDFS generator.
package ddfs_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_t;

  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 12;
  localparam int DEF_OUT_W  = 10;

  // Offset-binary code for zero amplitude at a given width.
  function automatic int unsigned MIDSCALE(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sin_qrom.sv
// Quarter-wave sine ROM, one-cycle synchronous read. Entries are sampled at
// half-step offsets so that mirrored quadrants reproduce the same set of
// magnitudes and the folded wave stays symmetric.
module sin_qrom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-2:0] data_o
);

  localparam int  DEPTH = 1 << ADDR_W;
  localparam int  RW    = DATA_W - 1;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'((1 << (DATA_W - 1)) - 1);

  logic [RW-1:0] rom [DEPTH];
  logic [RW-1:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real V = AMP * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH));
    assign rom[k] = RW'($rtoi(V + 0.5));
  end

  // Registered table read.
  always_ff @(posedge clk) data_q <= rom[addr_i];

  assign data_o = data_q;

endmodule

// File: rtl/ddfs_gen.sv
// Pipelined DDFS: S1 accumulate + capture controls, S2 phase/fold/ROM read,
// S3 amplitude scale + offset-binary output register.
// Assumes ADDR_W+2 >= 8 (square duty compare) and DATA_W >= ADDR_W+2.
module ddfs_gen import ddfs_pkg::*; #(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [ACC_W-1:0]  fw,
  input  logic              fw_load,
  input  logic [ADDR_W+1:0] phase_ofs,
  input  logic              phase_clr,
  input  logic [1:0]        wave_sel,
  input  logic [7:0]        duty,
  input  logic [7:0]        amp,
  output logic [OUT_W-1:0]  q,
  output logic              q_valid,
  output logic              wrap
);

  localparam int PW     = ADDR_W + 2;
  localparam int PRW    = DATA_W + 10;
  localparam int STAGES = 3;
  localparam logic signed [DATA_W-1:0] M_POS = DATA_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] M_NEG = -M_POS;

  // ---------------- S1: accumulator and control capture ----------------
  logic [ACC_W-1:0] acc_q, acc_d, fw_act_q, fw_act_d, fw_pend_q, fw_pend_d, fw_eff;
  logic [ACC_W:0]   sum;
  logic             pend_q, pend_d, clr_q, clr_d, wrap1_q, wrap1_d;
  wave_t            wave1_q, wave2_q;
  logic [7:0]       duty1_q, amp1_q, amp2_q;
  logic [STAGES:1]  vld_pipe;

  // Next-state for accumulator, pending word and clear request.
  always_comb begin
    fw_eff    = pend_q ? fw_pend_q : fw_act_q;
    sum       = {1'b0, acc_q} + {1'b0, fw_eff};
    acc_d     = acc_q;
    fw_act_d  = fw_act_q;
    fw_pend_d = fw_pend_q;
    pend_d    = pend_q;
    clr_d     = clr_q;
    wrap1_d   = wrap1_q;
    if (sample_en) begin
      acc_d    = clr_q ? '0 : sum[ACC_W-1:0];
      wrap1_d  = clr_q | sum[ACC_W];
      fw_act_d = fw_eff;
      pend_d   = 1'b0;
      clr_d    = 1'b0;
    end
    // A load coinciding with a sample only takes effect on the next sample.
    if (fw_load) begin
      fw_pend_d = fw;
      pend_d    = 1'b1;
    end
    if (phase_clr) clr_d = 1'b1;
  end

  // S1 state and per-sample control capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      fw_act_q  <= '0;
      fw_pend_q <= '0;
      pend_q    <= 1'b0;
      clr_q     <= 1'b0;
      wrap1_q   <= 1'b0;
      wave1_q   <= WAVE_SINE;
      duty1_q   <= '0;
      amp1_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      fw_act_q  <= fw_act_d;
      fw_pend_q <= fw_pend_d;
      pend_q    <= pend_d;
      clr_q     <= clr_d;
      wrap1_q   <= wrap1_d;
      if (sample_en) begin
        wave1_q <= wave_t'(wave_sel);
        duty1_q <= duty;
        amp1_q  <= amp;
      end
    end
  end

  // ---------------- S2: phase, quadrant fold, ROM read ----------------
  logic [PW-1:0]     p;
  logic [1:0]        qd;
  logic [ADDR_W-1:0] idx, rom_addr;
  logic [ADDR_W:0]   tri_mag;
  logic [DATA_W-2:0] tri_rep, rom_data;
  logic              tri_neg;
  logic signed [DATA_W-1:0] alt_d, alt2_q;
  logic              neg2_q, wrap2_q;

  assign p        = acc_q[ACC_W-1 -: PW] + phase_ofs;
  assign qd       = p[PW-1 -: 2];
  assign idx      = p[ADDR_W-1:0];
  assign rom_addr = qd[0] ? ~idx : idx;
  // Triangle magnitude is odd-valued so p and its mirror land on the same code.
  assign tri_mag  = {~rom_addr, 1'b1};
  assign tri_neg  = ~(qd[1] ^ qd[0]);

  // Stretch the triangle magnitude to full scale by bit replication.
  for (genvar j = 0; j < DATA_W - 1; j++) begin : g_rep
    assign tri_rep[j] = tri_mag[ADDR_W - ((DATA_W - 2 - j) % (ADDR_W + 1))];
  end

  sin_qrom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  // Non-sine waveforms are formed directly from the phase.
  always_comb begin
    alt_d = '0;
    case (wave1_q)
      WAVE_TRI: alt_d = tri_neg ? -$signed({1'b0, tri_rep}) : $signed({1'b0, tri_rep});
      WAVE_SAW: alt_d = DATA_W'({~p[PW-1], p[PW-2:0]}) << (DATA_W - PW);
      WAVE_SQR: alt_d = (p[PW-1 -: 8] < duty1_q) ? M_POS : M_NEG;
      default:  alt_d = '0;
    endcase
  end

  // S2 pipeline registers, aligned with the ROM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alt2_q  <= '0;
      neg2_q  <= 1'b0;
      wrap2_q <= 1'b0;
      wave2_q <= WAVE_SINE;
      amp2_q  <= '0;
    end else begin
      alt2_q  <= alt_d;
      neg2_q  <= qd[1];
      wrap2_q <= wrap1_q;
      wave2_q <= wave1_q;
      amp2_q  <= amp1_q;
    end
  end

  // ---------------- S3: amplitude scale and output ----------------
  logic signed [DATA_W-1:0] s3, sc;
  logic [8:0]               amp_p1;
  logic signed [9:0]        amp_s;
  logic [OUT_W-1:0]         q_q, q_d;
  logic                     wrap_q;

  // Select sine (sign-restored ROM) or the precomputed waveform.
  always_comb begin
    if (wave2_q == WAVE_SINE)
      s3 = neg2_q ? -$signed({1'b0, rom_data}) : $signed({1'b0, rom_data});
    else
      s3 = alt2_q;
  end

  assign amp_p1 = {1'b0, amp2_q} + 9'd1;
  assign amp_s  = $signed({1'b0, amp_p1});
  assign sc     = DATA_W'((PRW'(s3) * PRW'(amp_s)) >>> 8);
  assign q_d    = OUT_W'({~sc[DATA_W-1], sc[DATA_W-2:0]} >> (DATA_W - OUT_W));

  // Valid shift register and output register; q holds between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      q_q      <= OUT_W'(MIDSCALE(OUT_W));
      wrap_q   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], sample_en};
      wrap_q   <= vld_pipe[2] & wrap2_q;
      if (vld_pipe[2]) q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign q_valid = vld_pipe[STAGES];
  assign wrap    = wrap_q;

endmodule
